// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one PicoRV32 native memory port (CPU = requester 0).
// Define MEM_ARB_TIMEOUT_EN to enable the BUSY watchdog abort and sticky timeout_err.
module mem_arbiter #(
  parameter int PRIO_MODE      = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        grant,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e      state_q;
  logic        last_grant_q;
  logic        grant_q;
  logic        timeout_err_q;
  logic        instr_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        winner_d;
  logic        done_s;
  logic        abort_s;
  logic        finish_s;

  // Winner selection: a lone requester always wins; ties go by PRIO_MODE.
  always_comb begin
    winner_d = 1'b0;
    if (m0_valid && m1_valid) begin
      if (PRIO_MODE != 0) begin
        winner_d = 1'b0;
      end else begin
        winner_d = ~last_grant_q;
      end
    end else if (m1_valid) begin
      winner_d = 1'b1;
    end else begin
      winner_d = 1'b0;
    end
  end

  assign done_s = (state_q == BUSY) && mem_ready;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q;

  // Watchdog counts BUSY cycles without mem_ready; it sits at zero while IDLE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= 16'd0;
    end else if (state_q == IDLE) begin
      cnt_q <= 16'd0;
    end else if (!mem_ready) begin
      cnt_q <= cnt_q + 16'd1;
    end else begin
      cnt_q <= cnt_q;
    end
  end

  // A same-cycle mem_ready takes precedence over the abort.
  assign abort_s = (state_q == BUSY) && !mem_ready && (cnt_q == TMO_LAST);
`else
  assign abort_s = 1'b0;
`endif

  assign finish_s = done_s | abort_s;

  // Transaction FSM: latch the winner in IDLE, hold the request stable through BUSY.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      grant_q       <= 1'b0;
      instr_q       <= 1'b0;
      addr_q        <= 32'h0000_0000;
      wdata_q       <= 32'h0000_0000;
      wstrb_q       <= 4'h0;
      timeout_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (m0_valid || m1_valid) begin
            grant_q <= winner_d;
            instr_q <= winner_d ? m1_instr : m0_instr;
            addr_q  <= winner_d ? m1_addr  : m0_addr;
            wdata_q <= winner_d ? m1_wdata : m0_wdata;
            wstrb_q <= winner_d ? m1_wstrb : m0_wstrb;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (finish_s) begin
            last_grant_q <= grant_q;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (abort_s) begin
        timeout_err_q <= 1'b1;
      end
    end
  end

  assign mem_valid   = (state_q == BUSY);
  assign busy        = (state_q == BUSY);
  assign grant       = grant_q;
  assign mem_instr   = instr_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_wstrb   = wstrb_q;
  assign timeout_err = timeout_err_q;

  // Read data is shared; only the owner's ready qualifies it, zeroed on abort.
  assign m0_ready = finish_s & ~grant_q;
  assign m1_ready = finish_s & grant_q;
  assign m0_rdata = (abort_s && !grant_q) ? 32'h0000_0000 : mem_rdata;
  assign m1_rdata = (abort_s && grant_q)  ? 32'h0000_0000 : mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: round-robin and fixed-priority instances driven
// side by side, directed scenarios plus random traffic against a cycle-level reference model.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int TB_TMO = 4;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  typedef logic [138:0] obs_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_valid, m0_instr, m1_valid, m1_instr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [1:0]  mem_ready;
  logic [31:0] mem_rdata;

  logic [1:0]  o_m0_ready, o_m1_ready, o_mem_valid, o_mem_instr, o_grant, o_busy, o_err;
  logic [31:0] o_m0_rdata [2];
  logic [31:0] o_m1_rdata [2];
  logic [31:0] o_mem_addr [2];
  logic [31:0] o_mem_wdata [2];
  logic [3:0]  o_mem_wstrb [2];

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  // Instance 0 is round-robin, instance 1 is fixed priority.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_arbiter #(.PRIO_MODE(g), .TIMEOUT_CYCLES(TB_TMO)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_wstrb(m0_wstrb), .m0_ready(o_m0_ready[g]), .m0_rdata(o_m0_rdata[g]),
      .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_wstrb(m1_wstrb), .m1_ready(o_m1_ready[g]), .m1_rdata(o_m1_rdata[g]),
      .mem_valid(o_mem_valid[g]), .mem_instr(o_mem_instr[g]), .mem_addr(o_mem_addr[g]),
      .mem_wdata(o_mem_wdata[g]), .mem_wstrb(o_mem_wstrb[g]), .mem_ready(mem_ready[g]),
      .mem_rdata(mem_rdata), .grant(o_grant[g]), .busy(o_busy[g]), .timeout_err(o_err[g])
    );
  end

  // Reference model: one in-flight transaction record per instance.
  logic        mdl_busy [2], mdl_owner [2], mdl_last [2], mdl_err [2], mdl_instr [2];
  int          mdl_age [2];
  logic [31:0] mdl_addr [2], mdl_wdata [2];
  logic [3:0]  mdl_wstrb [2];

  function automatic logic tmo_hit(int k);
    return TMO_EN && mdl_busy[k] && !mem_ready[k] && (mdl_age[k] + 1 >= TB_TMO);
  endfunction

  function automatic logic pick(int k);
    if (m0_valid && m1_valid) return (k == 1) ? 1'b0 : !mdl_last[k];
    return m1_valid;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        mdl_busy[k] <= 1'b0; mdl_owner[k] <= 1'b0; mdl_last[k] <= 1'b1; mdl_err[k] <= 1'b0;
        mdl_instr[k] <= 1'b0; mdl_addr[k] <= 32'h0; mdl_wdata[k] <= 32'h0; mdl_wstrb[k] <= 4'h0;
        mdl_age[k] <= 0;
      end else if (mdl_busy[k]) begin
        if (mem_ready[k] || tmo_hit(k)) begin
          mdl_busy[k] <= 1'b0;
          mdl_last[k] <= mdl_owner[k];
          if (tmo_hit(k)) mdl_err[k] <= 1'b1;
        end else begin
          mdl_age[k] <= mdl_age[k] + 1;
        end
      end else if (m0_valid || m1_valid) begin
        mdl_busy[k]  <= 1'b1;
        mdl_age[k]   <= 0;
        mdl_owner[k] <= pick(k);
        mdl_instr[k] <= pick(k) ? m1_instr : m0_instr;
        mdl_addr[k]  <= pick(k) ? m1_addr  : m0_addr;
        mdl_wdata[k] <= pick(k) ? m1_wdata : m0_wdata;
        mdl_wstrb[k] <= pick(k) ? m1_wstrb : m0_wstrb;
      end
    end
  end

  function automatic obs_t exp_vec(int k);
    logic hit, fin;
    hit = tmo_hit(k);
    fin = mdl_busy[k] && (mem_ready[k] || hit);
    return {mdl_busy[k], mdl_owner[k], mdl_busy[k], mdl_instr[k], mdl_addr[k], mdl_wdata[k],
            mdl_wstrb[k], fin && !mdl_owner[k], fin && mdl_owner[k],
            (hit && !mdl_owner[k]) ? 32'h0 : mem_rdata, (hit && mdl_owner[k]) ? 32'h0 : mem_rdata,
            mdl_err[k]};
  endfunction

  function automatic obs_t got_vec(int k);
    return {o_busy[k], o_grant[k], o_mem_valid[k], o_mem_instr[k], o_mem_addr[k], o_mem_wdata[k],
            o_mem_wstrb[k], o_m0_ready[k], o_m1_ready[k], o_m0_rdata[k], o_m1_rdata[k], o_err[k]};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; m0_valid = 1'b0; m1_valid = 1'b0; mem_ready = 2'b00;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if ({o_busy[k], o_grant[k], o_mem_valid[k], o_mem_instr[k], o_mem_addr[k], o_mem_wdata[k],
           o_mem_wstrb[k], o_m0_ready[k], o_m1_ready[k], o_err[k]} !== 75'h0) begin
        errors++;
        $display("FAIL reset[%0d]: got busy=%b grant=%b valid=%b addr=%h wdata=%h wstrb=%h rdy=%b%b err=%b, required all zero",
                 k, o_busy[k], o_grant[k], o_mem_valid[k], o_mem_addr[k], o_mem_wdata[k],
                 o_mem_wstrb[k], o_m0_ready[k], o_m1_ready[k], o_err[k]);
      end
    end
  endtask

  task automatic test_single_read();
    do_reset();
    m0_valid = 1'b1; m0_instr = 1'b0; m0_addr = 32'h0000_0010; m0_wdata = $urandom; m0_wstrb = 4'h0;
    m1_valid = 1'b0; mem_ready = 2'b00;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 4) begin
        mem_ready = 2'b11; mem_rdata = 32'h0050_0093;
      end else begin
        mem_rdata = $urandom;
      end
      #1;
      vectors++;
      if ({o_mem_valid[0], o_mem_addr[0], o_mem_wstrb[0]} !== {1'b1, 32'h0000_0010, 4'h0}) begin
        errors++;
        $display("FAIL single_read downstream cyc%0d: got valid=%b addr=%h wstrb=%h, required 1/00000010/0",
                 i, o_mem_valid[0], o_mem_addr[0], o_mem_wstrb[0]);
      end
      vectors++;
      if ({o_m0_ready[0], o_m1_ready[0]} !== {(i == 4), 1'b0}) begin
        errors++;
        $display("FAIL single_read ready cyc%0d: got m0=%b m1=%b, required m0=%b m1=0",
                 i, o_m0_ready[0], o_m1_ready[0], (i == 4));
      end
    end
    vectors++;
    if (o_m0_rdata[0] !== 32'h0050_0093) begin
      errors++;
      $display("FAIL single_read rdata: got %h required 00500093", o_m0_rdata[0]);
    end
    @(negedge clk);
    m0_valid = 1'b0; mem_ready = 2'b00;
    #1;
    vectors++;
    if ({o_busy[0], o_m0_ready[0], o_m1_ready[0]} !== 3'b000) begin
      errors++;
      $display("FAIL single_read after: got busy=%b m0_ready=%b m1_ready=%b, required 0/0/0",
               o_busy[0], o_m0_ready[0], o_m1_ready[0]);
    end
  endtask

  task automatic test_write_latch();
    do_reset();
    m0_valid = 1'b0; m1_valid = 1'b1; m1_instr = 1'b0; m1_addr = 32'h0000_0100;
    m1_wdata = 32'hCAFE_BABE; m1_wstrb = 4'hF; mem_ready = 2'b00;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (i == 1) begin
        m1_addr = 32'h0000_0200; m1_wdata = $urandom; m1_wstrb = 4'h3;
      end
      if (i == 3) mem_ready = 2'b11;
      #1;
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if ({o_mem_addr[k], o_mem_wdata[k], o_mem_wstrb[k], o_grant[k]} !==
            {32'h0000_0100, 32'hCAFE_BABE, 4'hF, 1'b1}) begin
          errors++;
          $display("FAIL write_latch[%0d] cyc%0d: got %h/%h/%h grant=%b, required 00000100/cafebabe/f grant=1",
                   k, i, o_mem_addr[k], o_mem_wdata[k], o_mem_wstrb[k], o_grant[k]);
        end
      end
      vectors++;
      if ({o_m1_ready[0], o_m0_ready[0]} !== {(i == 3), 1'b0}) begin
        errors++;
        $display("FAIL write_latch ready cyc%0d: got m1=%b m0=%b, required m1=%b m0=0",
                 i, o_m1_ready[0], o_m0_ready[0], (i == 3));
      end
    end
    @(negedge clk);
    m1_valid = 1'b0; mem_ready = 2'b00;
    #1;
    vectors++;
    if (o_m1_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL write_latch second pulse: got m1_ready=%b required 0", o_m1_ready[0]);
    end
  endtask

  task automatic test_contention();
    logic exp_g;
    do_reset();
    m0_valid = 1'b1; m1_valid = 1'b1; m0_addr = $urandom; m1_addr = $urandom;
    m0_wstrb = 4'h0; m1_wstrb = 4'h0; mem_ready = 2'b11;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      vectors++;
      if (o_busy !== {2{(c % 2 == 1)}}) begin
        errors++;
        $display("FAIL contention busy c%0d: got %b required %b", c, o_busy, {2{(c % 2 == 1)}});
      end
      if (c % 2 == 1) begin
        exp_g = (((c - 1) / 2) % 2 == 1);
        vectors++;
        if (o_grant[0] !== exp_g) begin
          errors++;
          $display("FAIL contention rr grant c%0d: got %b required %b", c, o_grant[0], exp_g);
        end
        vectors++;
        if (o_grant[1] !== 1'b0) begin
          errors++;
          $display("FAIL contention fixed grant c%0d: got %b required 0", c, o_grant[1]);
        end
      end
    end
    @(negedge clk);
    m0_valid = 1'b0;
    @(negedge clk);
    #1;
    vectors++;
    if ({o_grant[1], o_m1_ready[1], o_m0_ready[1]} !== 3'b110) begin
      errors++;
      $display("FAIL contention fixed m1 served: got grant=%b m1_ready=%b m0_ready=%b, required 1/1/0",
               o_grant[1], o_m1_ready[1], o_m0_ready[1]);
    end
    @(negedge clk);
    m1_valid = 1'b0; mem_ready = 2'b00;
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    m0_valid = 1'b1; m1_valid = 1'b0; m0_addr = $urandom; m0_wstrb = 4'h0; mem_ready = 2'b00;
    @(negedge clk);
    #1;
    vectors++;
    if (o_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid setup: got busy=%b required 1", o_busy[0]);
    end
    reset_n = 1'b0; m1_valid = 1'b1;
    @(negedge clk);
    #1;
    vectors++;
    if ({o_busy[0], o_mem_valid[0], o_m0_ready[0]} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid abandon: got busy=%b mem_valid=%b m0_ready=%b, required 0/0/0",
               o_busy[0], o_mem_valid[0], o_m0_ready[0]);
    end
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    vectors++;
    if ({o_busy, o_grant} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_mid first tie: got busy=%b grant=%b, required busy=11 grant=00", o_busy, o_grant);
    end
    mem_ready = 2'b11;
    @(negedge clk);
    m0_valid = 1'b0; m1_valid = 1'b0; mem_ready = 2'b00;
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    m0_valid = 1'b1; m1_valid = 1'b0; m0_wstrb = 4'h0; m0_addr = $urandom; mem_ready = 2'b00;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      mem_rdata = $urandom | 32'h1;
      #1;
      vectors++;
      if ({o_m0_ready[0], o_err[0]} !== {(i == 4), 1'b0}) begin
        errors++;
        $display("FAIL timeout ready cyc%0d: got m0_ready=%b err=%b, required %b/0", i, o_m0_ready[0], o_err[0], (i == 4));
      end
      if (i == 4) begin
        vectors++;
        if (o_m0_rdata[0] !== 32'h0) begin
          errors++;
          $display("FAIL timeout rdata: got %h required 00000000", o_m0_rdata[0]);
        end
      end
    end
    @(negedge clk);
    m0_valid = 1'b0;
    #1;
    vectors++;
    if ({o_busy[0], o_mem_valid[0], o_err[0]} !== 3'b001) begin
      errors++;
      $display("FAIL timeout after abort: got busy=%b valid=%b err=%b, required 0/0/1", o_busy[0], o_mem_valid[0], o_err[0]);
    end
    m1_valid = 1'b1; m1_wstrb = 4'h0; m1_addr = $urandom;
    @(negedge clk);
    mem_ready = 2'b11; mem_rdata = 32'h1234_5678;
    #1;
    vectors++;
    if ({o_m1_ready[0], o_m1_rdata[0], o_err[0]} !== {1'b1, 32'h1234_5678, 1'b1}) begin
      errors++;
      $display("FAIL timeout recovery: got m1_ready=%b rdata=%h err=%b, required 1/12345678/1",
               o_m1_ready[0], o_m1_rdata[0], o_err[0]);
    end
    @(negedge clk);
    m1_valid = 1'b0; mem_ready = 2'b00;
  endtask
`else
  task automatic test_no_timeout();
    do_reset();
    m0_valid = 1'b1; m1_valid = 1'b0; m0_wstrb = 4'h0; m0_addr = $urandom; mem_ready = 2'b00;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      #1;
      vectors++;
      if ({o_busy[0], o_m0_ready[0], o_err[0]} !== 3'b100) begin
        errors++;
        $display("FAIL no_timeout cyc%0d: got busy=%b m0_ready=%b err=%b, required 1/0/0", i, o_busy[0], o_m0_ready[0], o_err[0]);
      end
    end
    mem_ready = 2'b11;
    @(negedge clk);
    m0_valid = 1'b0; mem_ready = 2'b00;
  endtask
`endif

  task automatic test_random_traffic(input int n);
    obs_t got, exp;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      reset_n  = ($urandom_range(0, 63) != 0);
      m0_valid = ($urandom_range(0, 2) != 0);
      m1_valid = ($urandom_range(0, 2) != 0);
      m0_instr = 1'($urandom); m1_instr = 1'($urandom);
      m0_addr  = $urandom; m1_addr = $urandom; m0_wdata = $urandom; m1_wdata = $urandom;
      m0_wstrb = 4'($urandom); m1_wstrb = 4'($urandom);
      mem_ready = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
      mem_rdata = $urandom;
      #1;
      for (int k = 0; k < 2; k++) begin
        got = got_vec(k);
        exp = exp_vec(k);
        vectors++;
        if (got !== exp) begin
          errors++;
          $display("FAIL random[%0d] cycle %0d: got %h required %h", k, c, got, exp);
        end
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    m0_valid = 1'b0; m0_instr = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_wstrb = 4'h0;
    m1_valid = 1'b0; m1_instr = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_wstrb = 4'h0;
    mem_ready = 2'b00; mem_rdata = 32'h0;
    test_reset();
    test_single_read();
    test_write_latch();
    test_contention();
    test_reset_mid_busy();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    do_reset();
    test_random_traffic(800);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
